// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg : shared constants and types for the display scan multiplexer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 5;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

  // Tick counter width: wide enough for the longer of the two phases, at least 1 bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_if.sv
// ---------------------------------------------------------------------------
// disp_if : scan-mux control/data bundle (master = host side, slave = mux)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface disp_if;
  import disp_pkg::*;

  logic                  en;
  logic                  load;
  logic [15:0]           value_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [DIGIT_W-1:0]    digit_data;
  logic [NUM_DIGITS-1:0] anode;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output en, load, value_in, dp_in,
    input  digit_data, anode, frame_done, pending
  );

  modport slave (
    input  en, load, value_in, dp_in,
    output digit_data, anode, frame_done, pending
  );

endinterface

`default_nettype wire

// File: rtl/disp_lzb_mask.sv
// ---------------------------------------------------------------------------
// disp_lzb_mask : marks leading-zero digits (above digit 0, dp clear) for blanking
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module disp_lzb_mask
  import disp_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [NUM_DIGITS-1:0]   mask_o
);

  logic zero_above;

  // Walk from the most significant digit down; digit 0 is never masked.
  always_comb begin
    mask_o     = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (value_i[4*i +: 4] == 4'h0);
      mask_o[i]  = zero_above & ~dp_i[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_scan_mux.sv
// ---------------------------------------------------------------------------
// disp_scan_mux : 4-digit scan multiplexer with frame-synchronous double buffering
// Revision : 1.0   Optional: DISP_LZB_EN enables leading-zero blanking.
// ---------------------------------------------------------------------------
`default_nettype none

module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int DIG_TICKS   = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic  clk,
  input  logic  rst_n,
  disp_if.slave bus
);

  localparam int TW = cnt_w(DIG_TICKS, BLANK_TICKS);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0]         DIG_LAST   = TW'(DIG_TICKS - 1);
  localparam logic [TW-1:0]         BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [15:0]           act_val_q, act_val_d, shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic                  pend_q, pend_d;
  logic                  en_q;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [DIGIT_W-1:0]    data_q, data_d;
  logic                  fdone_q, fdone_d;
  logic                  wrap, restart, commit;
  logic [15:0]           src_val;
  logic [NUM_DIGITS-1:0] src_dp;
  logic [NUM_DIGITS-1:0] blank_mask;

`ifdef DISP_LZB_EN
  disp_lzb_mask u_lzb (
    .value_i (act_val_q),
    .dp_i    (act_dp_q),
    .mask_o  (blank_mask)
  );
`else
  assign blank_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SHOW;
      idx_q     <= '0;
      tick_q    <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      pend_q    <= 1'b0;
      en_q      <= 1'b0;
      anode_q   <= ANODE_OFF;
      data_q    <= '0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      pend_q    <= pend_d;
      en_q      <= bus.en;
      anode_q   <= anode_d;
      data_q    <= data_d;
      fdone_q   <= fdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q + TW'(1);
    wrap    = 1'b0;
    if (!bus.en) begin
      state_d = SHOW;
      idx_d   = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        SHOW: begin
          if (tick_q == DIG_LAST) begin
            tick_d = '0;
            if (BLANK_TICKS == 0) begin
              idx_d = idx_q + IW'(1);
              wrap  = (idx_q == IDX_LAST);
            end else begin
              state_d = BLANK;
            end
          end
        end
        BLANK: begin
          if (tick_q == BLANK_LAST) begin
            tick_d  = '0;
            state_d = SHOW;
            idx_d   = idx_q + IW'(1);
            wrap    = (idx_q == IDX_LAST);
          end
        end
        default: state_d = SHOW;
      endcase
    end
  end

  // The first enabled cycle after a dark period acts as a frame boundary too.
  assign restart = bus.en & ~en_q;
  assign commit  = wrap | restart;

  always_comb begin
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    pend_d    = pend_q;
    if (commit) begin
      pend_d = 1'b0;
      if (bus.load) begin
        act_val_d = bus.value_in;
        act_dp_d  = bus.dp_in;
      end else if (pend_q) begin
        act_val_d = shd_val_q;
        act_dp_d  = shd_dp_q;
      end
    end else if (bus.load) begin
      shd_val_d = bus.value_in;
      shd_dp_d  = bus.dp_in;
      pend_d    = 1'b1;
    end
  end

  // On restart the freshly committed value must already reach digit 0.
  assign src_val = restart ? act_val_d : act_val_q;
  assign src_dp  = restart ? act_dp_d  : act_dp_q;

  always_comb begin
    anode_d = ANODE_OFF;
    data_d  = data_q;
    fdone_d = wrap;
    if (bus.en && state_q == SHOW) begin
      if (!blank_mask[idx_q]) anode_d = ~(ONE_HOT0 << idx_q);
      data_d = {src_dp[idx_q], src_val[{idx_q, 2'b00} +: 4]};
    end
  end

  assign bus.anode      = anode_q;
  assign bus.digit_data = data_q;
  assign bus.frame_done = fdone_q;
  assign bus.pending    = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_mux : two scan muxes (blanking 1 and 0 ticks) against a frame-position model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_disp_scan_mux;
  import disp_pkg::*;

  localparam int DT = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_on = 1'b0;

  logic [3:0] SEQ0 [21] = '{4'hE,4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hD,4'hF,
                            4'hB,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'h7,4'hF,4'hE};
  logic [3:0] SEQ1 [17] = '{4'hE,4'hE,4'hE,4'hE,4'hD,4'hD,4'hD,4'hD,
                            4'hB,4'hB,4'hB,4'hB,4'h7,4'h7,4'h7,4'h7,4'hE};

  disp_if if0 ();
  disp_if if1 ();

  assign if0.en = en;  assign if0.load = load;  assign if0.value_in = value;  assign if0.dp_in = dp;
  assign if1.en = en;  assign if1.load = load;  assign if1.value_in = value;  assign if1.dp_in = dp;

  disp_scan_mux #(.DIG_TICKS(DT), .BLANK_TICKS(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  disp_scan_mux #(.DIG_TICKS(DT), .BLANK_TICKS(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int an2idx(input logic [3:0] a);
    case (a)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic lz_hidden(input int d, input logic [15:0] v, input logic [3:0] dpv);
`ifdef DISP_LZB_EN
    logic [15:0] sh;
    sh = v >> (4 * d);
    return (d > 0) && (sh == 16'h0) && !dpv[d];
`else
    return 1'b0;
`endif
  endfunction

  // Model: each instance is a position within a frame of 4*(DT+blank) cycles.
  logic [3:0]  m_an [2];
  logic [4:0]  m_dd [2];
  logic        m_fd [2], m_pd [2], m_enp [2];
  logic [15:0] m_av [2], m_sv [2];
  logic [3:0]  m_ad [2], m_sd [2];
  int          m_pos [2];

  always @(posedge clk) begin : p_model
    int s, p, dig;
    logic wr, rs;
    logic [15:0] nv;
    logic [3:0]  nd, oh;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_an[k] = 4'hF; m_dd[k] = '0; m_fd[k] = 1'b0; m_pd[k] = 1'b0; m_enp[k] = 1'b0;
        m_av[k] = '0;   m_sv[k] = '0; m_ad[k] = '0;   m_sd[k] = '0;   m_pos[k] = 0;
      end else begin
        s  = DT + ((k == 0) ? 1 : 0);
        p  = 4 * s;
        wr = en && (m_pos[k] == p - 1);
        rs = en && !m_enp[k];
        nv = m_av[k];
        nd = m_ad[k];
        if (wr || rs) begin
          if (load) begin nv = value; nd = dp; end
          else if (m_pd[k]) begin nv = m_sv[k]; nd = m_sd[k]; end
          m_pd[k] = 1'b0;
        end else if (load) begin
          m_sv[k] = value; m_sd[k] = dp; m_pd[k] = 1'b1;
        end
        if (!en) begin
          m_an[k] = 4'hF;
        end else begin
          dig = m_pos[k] / s;
          if (m_pos[k] % s >= DT) begin
            m_an[k] = 4'hF;
          end else begin
            oh = 4'b0001 << dig;
            m_an[k] = lz_hidden(dig, m_av[k], m_ad[k]) ? 4'hF : ~oh;
            m_dd[k] = rs ? {nd[dig], nv[4*dig +: 4]} : {m_ad[k][dig], m_av[k][4*dig +: 4]};
          end
        end
        m_fd[k]  = wr;
        m_av[k]  = nv;
        m_ad[k]  = nd;
        m_pos[k] = en ? (m_pos[k] + 1) % p : 0;
        m_enp[k] = en;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("anode0", if0.anode, m_an[0]);      chk("anode1", if1.anode, m_an[1]);
      chk("data0", if0.digit_data, m_dd[0]);  chk("data1", if1.digit_data, m_dd[1]);
      chk("fdone0", if0.frame_done, m_fd[0]); chk("fdone1", if1.frame_done, m_fd[1]);
      chk("pend0", if0.pending, m_pd[0]);     chk("pend1", if1.pending, m_pd[1]);
    end
  end

  task automatic wait_fd();
    int n = 0;
    @(negedge clk);
    while (!if0.frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fd", int'(n < 100), 1);
  endtask

  task automatic frame_check(input string name, input logic [19:0] exp, input bit np);
    for (int i = 0; i < 19; i++) begin
      int d;
      @(negedge clk);
      d = an2idx(if0.anode);
      if (d >= 0) chk(name, if0.digit_data, exp[5*d +: 5]);
      if (np) chk("no_pend", if0.pending, 0);
    end
  endtask

  task automatic lzb_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] exp);
    logic [3:0] seen;
    int ix;
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ix = an2idx(if0.anode);
      if (ix >= 0) seen[ix] = 1'b1;
    end
    chk("lzb_seen", seen, exp);
  endtask

  initial begin : p_main
    int n;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_anode0", if0.anode, 4'hF);    chk("rst_anode1", if1.anode, 4'hF);
    chk("rst_data0", if0.digit_data, 0);   chk("rst_fd0", if0.frame_done, 0);
    chk("rst_pend0", if0.pending, 0);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk("seq0", if0.anode, SEQ0[i]);
      chk("seq_fd0", if0.frame_done, int'(i == 19));
      if (i < 17) begin
        chk("seq1", if1.anode, SEQ1[i]);
        chk("seq_fd1", if1.frame_done, int'(i == 15));
      end
    end

    value = 16'h1A2F; dp = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pend_set", if0.pending, 1);
    n = 0;
    while (!if0.frame_done && n < 100) begin
      if (if0.anode != 4'hF) chk("old_val", if0.digit_data, 0);
      @(negedge clk);
      n++;
    end
    chk("wrap_seen", int'(n < 100), 1);
    chk("pend_clr", if0.pending, 0);
    frame_check("new_val", {5'h01, 5'h1A, 5'h02, 5'h0F}, 1'b0);

    @(negedge clk);
    repeat (3) @(negedge clk);
    value = 16'h1111; dp = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    value = 16'h2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    frame_check("last_wins", {4{5'h02}}, 1'b0);

    // frame_check leaves us one cycle before the wrap edge.
    value = 16'h5678; dp = 4'b0001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("wrap_fd", if0.frame_done, 1);
    chk("wrap_nopend", if0.pending, 0);
    frame_check("wrap_load", {5'h05, 5'h06, 5'h07, 5'h18}, 1'b1);

    n = 0;
    while (if0.anode != 4'hB && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("find_d2", int'(n < 100), 1);
    en = 1'b0;
    @(negedge clk);
    chk("dis_an0", if0.anode, 4'hF);
    chk("dis_an1", if1.anode, 4'hF);
    value = 16'hC0DE; dp = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("dis_pend", if0.pending, 1);
    repeat (3) @(negedge clk);
    chk("dis_pend_hold", if0.pending, 1);
    chk("dis_fd", if0.frame_done, 0);
    en = 1'b1;
    @(negedge clk);
    chk("ren_anode", if0.anode, 4'hE);
    chk("ren_data", if0.digit_data, 5'h0E);
    chk("ren_pend", if0.pending, 0);

`ifdef DISP_LZB_EN
    lzb_frame(16'h0050, 4'b0000, 4'b0011);
    lzb_frame(16'h0000, 4'b0000, 4'b0001);
    lzb_frame(16'h0000, 4'b1000, 4'b1001);
`else
    lzb_frame(16'h0050, 4'b0000, 4'b1111);
    lzb_frame(16'h0000, 4'b0000, 4'b1111);
    lzb_frame(16'h0000, 4'b1000, 4'b1111);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst0", if0.anode, 4'hF);
        chk("async_rst1", if1.anode, 4'hF);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end
      if (en && $urandom_range(0, 39) == 0)       en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0)  en = 1'b1;
      load = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0:       value = 16'($urandom);
        1:       value = 16'($urandom) & 16'h0FFF;
        2:       value = 16'($urandom) & 16'h00FF;
        3:       value = 16'($urandom) & 16'h000F;
        default: value = 16'h0000;
      endcase
      dp = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Time-multiplexes a 4-digit hex value plus 4 decimal points onto one shared seven-segment decoder.
- Sits directly upstream of the 7-segment decoder: drives its 5-bit digit input {dp, nibble} and the board's active-low digit anodes.
- New values are double-buffered and committed only at frame boundaries, so a displayed frame is never torn.
- Inter-digit blanking suppresses ghosting.

Parameters:
- DIG_TICKS, 50000, clock cycles each digit is lit (1 kHz/digit at 50 MHz); legal range ≥1.
- BLANK_TICKS, 500, clock cycles all anodes are off between digits; 0 disables blanking.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low = display dark and scan held.
- load  in  1  single-cycle strobe: capture value_in/dp_in into shadow.
- value_in  in  16  four hex nibbles; digit 0 = [3:0].
- dp_in  in  4  decimal point per digit; bit i = digit i.
- digit_data  out  5  {dp, nibble} of current digit, to decoder input.
- anode  out  4  active-low digit enables, one-hot-low or all-high.
- frame_done  out  1  one-cycle pulse at each frame wrap.
- pending  out  1  shadow holds an uncommitted load.

Behaviour:
- Reset (async, rst_n=0): anode=4'hF, digit_data=5'h00, frame_done=0, pending=0, active/shadow value=0, dp=0, dig_idx=0, tick_cnt=0, state=SHOW.
- All outputs registered; anode and digit_data change on the same edge.
- Two states:
  - SHOW: anode[dig_idx]=0, others 1.
  - BLANK: anode=4'hF.
- SHOW → BLANK after DIG_TICKS cycles (tick_cnt counts 0..DIG_TICKS-1, then clears).
- BLANK → SHOW after BLANK_TICKS cycles, with dig_idx+1.
- BLANK_TICKS=0: SHOW → SHOW directly, with dig_idx+1.
- digit_data = {active_dp[dig_idx], active_val[4*dig_idx+:4]}; held constant through the following BLANK.
- Frame wrap occurs when dig_idx advances 3→0. On that cycle:
  - frame_done=1.
  - If pending, active ← shadow and pending ← 0.
  - The first SHOW of digit 0 displays the new value.
- load=1 sets shadow ← {value_in, dp_in} and pending ← 1. Later loads before the wrap overwrite the shadow (last wins).
- load coincident with wrap: the coincident value_in/dp_in is committed directly to active; pending stays 0.
- en=0:
  - Synchronously forces state=SHOW, dig_idx=0, tick_cnt=0, anode=4'hF.
  - frame_done stays 0.
  - load/shadow/pending still operate.
  - No commit occurs while en=0.
- en rising: digit 0 is lit on the next cycle. If pending, the shadow is committed on that first enabled cycle.
- Reset mid-frame: anodes off immediately (async); scan restarts at digit 0 after rst_n release.
- Counter widths: $clog2 of max(DIG_TICKS, BLANK_TICKS, 2); no overflow path.

Optional Feature:
- Macro: DISP_LZB_EN (leading-zero blanking).
- With macro:
  - Any digit i>0 whose nibble and all higher active nibbles are zero keeps its anode high during SHOW, unless active_dp[i]=1.
  - Digit 0 is always shown.
  - Timing and frame_done are unchanged.
- Without macro: all four digits are always lit in turn.

Decomposition:
- Package disp_pkg:
  - NUM_DIGITS=4.
  - State enum {SHOW, BLANK}.
  - ANODE_OFF=4'hF.
  - DIGIT_W=5.
- Sub-module disp_lzb_mask: combinational, 16-bit value + 4-bit dp → 4-bit blank mask. Instantiated only under DISP_LZB_EN.

Test Plan:
- Bench parameters: DIG_TICKS=4, BLANK_TICKS=1.
- Reset release with en=1, value 0 → anode sequence: E (4 clk), F (1), D (4), F, B, F, 7, F. frame_done pulses on the 7→F→E wrap cycle.
- load value_in=16'h1A2F, dp_in=4'b0100 mid-frame:
  - pending=1 until wrap.
  - Next frame digit_data = 0F, 02, 1A, 01 (digits 0..3).
  - Current frame still shows old value.
- Two loads (16'h1111 then 16'h2222) in the same frame → only 2222 displayed; load exactly on wrap cycle → committed that cycle, pending never asserts.
- BLANK_TICKS=0 build → anode E, D, B, 7 with no F cycles; period 16 clk.
- en dropped mid-digit-2:
  - anode=F next cycle.
  - A load while disabled keeps pending=1.
  - On en re-raise: digit 0 is lit with the new value and pending clears.
- DISP_LZB_EN, value 16'h0050, dp 0 → digits 0,1 lit, 2,3 anodes stay F; value 0 → only digit 0 lit; dp_in=4'b1000 → digit 3 also lit.
